frame_load_sched: RTL and testbench

- Schedules SPI-flash frame loads into the matrix frame buffer on behalf of several requesters: the time layers (hour, minute, second) and the button-selected frame.
- Latches the latest frame index per requester and arbitrates round-robin.
- Launches one load at a time on the loader's start/done handshake, and only during display blanking.
- Sits between the timekeeping/button logic and the SPI shift loader.

---
 rtl/frame_load_sched.sv | 223 ++++++++++++++++++++++
 tb/tb_frame_load_sched.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_load_sched.sv
// ---------------------------------------------------------------------------
// frame_load_sched
//
// Schedules SPI-flash frame loads into the matrix frame buffer on behalf of
// several requesters (hour / minute / second layers and the button frame).
// Each requester strobes in a frame index; the latest index per requester is
// kept together with a pending flag. Pending requesters are served
// round-robin, one load at a time, over the loader's start/done handshake.
// A load is launched only while the display is blanking and the loader is
// idle. Loads that never complete are abandoned after TIMEOUT_CYC cycles and
// flagged with a sticky error.
//
// Ports:
//   clk_50       system clock
//   rst          asynchronous active-high reset (loader shares this reset)
//   req_valid    per-requester strobe, captures that requester's frame index
//   req_frame    frame indices, requester i in bits [8i+7:8i]
//   blank        display blanking window, loads launch only while high
//   ld_busy      loader busy
//   ld_done      one-cycle completion pulse from the loader
//   err_clr      clears err_timeout
//   ld_start     one-cycle launch pulse to the loader
//   ld_addr      flash byte address of the frame being loaded (held stable)
//   ld_layer     requester/layer index of the load in flight
//   pending      per-requester pending flags
//   active       high while a load is in flight (launch and wait)
//   done_layer   one-hot one-cycle completion pulse
//   err_timeout  sticky load-timeout flag
// ---------------------------------------------------------------------------
module frame_load_sched #(
  parameter int          NUM_REQ     = 3,
  parameter int          FRAME_BYTES = 1024,
  parameter logic [23:0] BASE_ADDR   = 24'h000000,
  parameter int          TIMEOUT_CYC = 65535
) (
  input  logic                 clk_50,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_frame,
  input  logic                 blank,
  input  logic                 ld_busy,
  input  logic                 ld_done,
  input  logic                 err_clr,
  output logic                 ld_start,
  output logic [23:0]          ld_addr,
  output logic [1:0]           ld_layer,
  output logic [NUM_REQ-1:0]   pending,
  output logic                 active,
  output logic [NUM_REQ-1:0]   done_layer,
  output logic                 err_timeout
);

  // The wait counter runs 0..TIMEOUT_CYC-1; hitting the last value without a
  // done means TIMEOUT_CYC wait cycles have elapsed.
  localparam int               CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;

  logic [7:0]         frame_reg [NUM_REQ];
  logic [1:0]         rr_ptr;
  logic [CNT_W-1:0]   cnt;

  logic               grant_found;
  logic [1:0]         winner;
  logic [1:0]         cand;
  logic [NUM_REQ-1:0] grant_mask;
  logic [23:0]        addr_calc;
  logic               grant;
  logic               done_hit;
  logic               timeout_hit;

  // Round-robin arbiter: scan upward starting just after the last winner,
  // wrapping modulo NUM_REQ, and take the first pending requester found.
  always_comb begin
    grant_found = 1'b0;
    winner      = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = 2'((int'(rr_ptr) + k) % NUM_REQ);
      if (!grant_found && pending[cand]) begin
        grant_found = 1'b1;
        winner      = cand;
      end
    end
  end

  // Flash address of the winner's currently stored frame. The arithmetic is
  // deliberately kept in 24 bits so large indices wrap modulo 2^24.
  always_comb begin
    addr_calc = BASE_ADDR + (24'(frame_reg[winner]) * 24'(FRAME_BYTES));
  end

  // Next-state and output decode. A launch needs something pending, the
  // blanking window and an idle loader. In WAIT a done takes priority over
  // a timeout landing in the same cycle. A done seen during LAUNCH is not
  // looked at.
  always_comb begin
    state_next  = state;
    grant       = 1'b0;
    done_hit    = 1'b0;
    timeout_hit = 1'b0;
    ld_start    = 1'b0;
    active      = 1'b0;
    case (state)
      IDLE: begin
        if (grant_found && blank && !ld_busy) begin
          grant      = 1'b1;
          state_next = LAUNCH;
        end
      end
      LAUNCH: begin
        ld_start   = 1'b1;
        active     = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        active = 1'b1;
        if (ld_done) begin
          done_hit   = 1'b1;
          state_next = IDLE;
        end else if (cnt == CNT_LAST) begin
          timeout_hit = 1'b1;
          state_next  = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // One-hot mask of the requester whose pending flag is consumed by a grant.
  always_comb begin
    grant_mask = '0;
    if (grant) begin
      grant_mask = NUM_REQ'(1) << winner;
    end
  end

  // State register.
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Request capture. A new strobe always overwrites the stored index, so the
  // latest value wins. A strobe on the requester being granted in the same
  // cycle re-sets its flag after the grant consumed the old index, which is
  // why the strobe term is OR-ed in after the mask is applied.
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      pending <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        frame_reg[i] <= '0;
      end
    end else begin
      pending <= (pending & ~grant_mask) | req_valid;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i]) begin
          frame_reg[i] <= req_frame[8*i +: 8];
        end
      end
    end
  end

  // Launch bookkeeping. Address and layer are captured at grant time and
  // stay untouched until the next grant, so they are stable for the whole
  // load. The pointer starts at the last requester so that requester 0 is
  // first in line after reset.
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      ld_addr  <= '0;
      ld_layer <= '0;
      rr_ptr   <= 2'(NUM_REQ - 1);
    end else if (grant) begin
      ld_addr  <= addr_calc;
      ld_layer <= winner;
      rr_ptr   <= winner;
    end
  end

  // Timeout counter: cleared in LAUNCH and counting every WAIT cycle.
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == LAUNCH) begin
      cnt <= '0;
    end else if (state == WAIT) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Completion pulse and sticky error. A timeout in the same cycle as
  // err_clr leaves the flag set.
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      done_layer  <= '0;
      err_timeout <= 1'b0;
    end else begin
      done_layer <= '0;
      if (done_hit) begin
        done_layer <= NUM_REQ'(1) << ld_layer;
      end
      if (timeout_hit) begin
        err_timeout <= 1'b1;
      end else if (err_clr) begin
        err_timeout <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_frame_load_sched.sv
// ---------------------------------------------------------------------------
// tb_frame_load_sched
//
// Directed steps followed by a randomized phase for frame_load_sched
// (TIMEOUT_CYC shortened to 16). A transaction-level reference model,
// stepped once per clock edge, predicts launches, winners, addresses,
// completions, timeouts and pending flags.
// ---------------------------------------------------------------------------
module tb_frame_load_sched;

  localparam int TO = 16;

  logic        clk_50 = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req_valid = '0;
  logic [23:0] req_frame = '0;
  logic        blank = 1'b0;
  logic        ld_busy = 1'b0;
  logic        ld_done = 1'b0;
  logic        err_clr = 1'b0;
  logic        ld_start;
  logic [23:0] ld_addr;
  logic [1:0]  ld_layer;
  logic [2:0]  pending;
  logic        active;
  logic [2:0]  done_layer;
  logic        err_timeout;

  int n_checks = 0;
  int n_fails  = 0;

  frame_load_sched #(
    .NUM_REQ    (3),
    .FRAME_BYTES(1024),
    .BASE_ADDR  (24'h000000),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk_50     (clk_50),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_frame  (req_frame),
    .blank      (blank),
    .ld_busy    (ld_busy),
    .ld_done    (ld_done),
    .err_clr    (err_clr),
    .ld_start   (ld_start),
    .ld_addr    (ld_addr),
    .ld_layer   (ld_layer),
    .pending    (pending),
    .active     (active),
    .done_layer (done_layer),
    .err_timeout(err_timeout)
  );

  always #5 clk_50 = ~clk_50;

  // Comparison point shared by directed steps and the model monitor.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one request cycle (strobes plus frames) and drop the strobes.
  task automatic applyStimulus(input logic [2:0] valid, input logic [23:0] frames);
    req_valid = valid;
    req_frame = frames;
    @(negedge clk_50);
    req_valid = '0;
  endtask

  task automatic waitStart(input string tag);
    int n;
    n = 0;
    while (ld_start !== 1'b1 && n < 64) begin
      @(negedge clk_50);
      n++;
    end
    checkOutput(tag, 32'(ld_start), 32'd1);
  endtask

  task automatic checkLaunch(input string tag, input int layer, input logic [23:0] addr);
    checkOutput({tag, " start"}, 32'(ld_start), 32'd1);
    checkOutput({tag, " layer"}, 32'(ld_layer), 32'(layer));
    checkOutput({tag, " addr"}, 32'(ld_addr), 32'(addr));
  endtask

  // Called at the negedge right after the launch edge; returns done so the
  // loader completes 'delay' edges after that launch edge.
  task automatic endLoadAfter(input int layer, input int delay);
    repeat (delay - 1) @(negedge clk_50);
    ld_done = 1'b1;
    @(negedge clk_50);
    ld_done = 1'b0;
    checkOutput("done_layer pulse", 32'(done_layer), 32'(3'b001 << layer));
    checkOutput("active after done", 32'(active), 32'd0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    req_valid = '0;
    ld_done = 1'b0;
    err_clr = 1'b0;
    repeat (2) @(negedge clk_50);
    checkOutput("reset ld_start", 32'(ld_start), 32'd0);
    checkOutput("reset ld_addr", 32'(ld_addr), 32'd0);
    checkOutput("reset ld_layer", 32'(ld_layer), 32'd0);
    checkOutput("reset pending", 32'(pending), 32'd0);
    checkOutput("reset active", 32'(active), 32'd0);
    checkOutput("reset done_layer", 32'(done_layer), 32'd0);
    checkOutput("reset err_timeout", 32'(err_timeout), 32'd0);
    rst = 1'b0;
  endtask

  // ---------------- reference model ----------------
  bit          m_pend [3];
  logic [7:0]  m_frame [3];
  int          m_ptr;
  bit          m_busy;
  int          m_k;
  int          m_layer;
  logic [23:0] m_addr;
  bit          m_err;

  // Model step once per edge, sampled 1 time unit after it. The model holds
  // the latest frame per layer, serves pending layers in rotation after the
  // last winner, and counts edges since a launch: the edge after the launch
  // ignores done, and with no done by edge TO+1 the load times out.
  always @(posedge clk_50) begin
    bit         was_busy;
    bit         exp_start;
    bit         timeout;
    bit         found;
    int         w;
    int         idx;
    logic [2:0] exp_done;
    logic [2:0] pv;
    #1;
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        m_pend[i]  = 1'b0;
        m_frame[i] = 8'd0;
      end
      m_ptr = 2; m_busy = 1'b0; m_k = 0; m_layer = 0; m_addr = '0; m_err = 1'b0;
    end else begin
      was_busy = m_busy;
      timeout  = 1'b0;
      exp_done = 3'b000;
      if (m_busy) begin
        m_k++;
        if (m_k >= 2 && ld_done) begin
          m_busy = 1'b0;
          exp_done = 3'b001 << m_layer;
        end else if (m_k == TO + 1) begin
          m_busy = 1'b0;
          timeout = 1'b1;
        end
      end
      if (timeout) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
      exp_start = !was_busy && blank && !ld_busy && (m_pend[0] || m_pend[1] || m_pend[2]);
      checkOutput("mon ld_start", 32'(ld_start), 32'(exp_start));
      if (exp_start) begin
        found = 1'b0;
        w = 0;
        for (int k = 1; k <= 3; k++) begin
          idx = (m_ptr + k) % 3;
          if (!found && m_pend[idx]) begin
            w = idx;
            found = 1'b1;
          end
        end
        m_pend[w] = 1'b0;
        m_ptr   = w;
        m_busy  = 1'b1;
        m_k     = 0;
        m_layer = w;
        m_addr  = 24'(m_frame[w] * 1024);
        checkOutput("mon ld_layer", 32'(ld_layer), 32'(w));
      end
      if (m_busy) checkOutput("mon ld_addr", 32'(ld_addr), 32'(m_addr));
      for (int i = 0; i < 3; i++) begin
        if (req_valid[i]) begin
          m_pend[i]  = 1'b1;
          m_frame[i] = req_frame[8*i +: 8];
        end
      end
      pv = {m_pend[2], m_pend[1], m_pend[0]};
      checkOutput("mon active", 32'(active), 32'(m_busy));
      checkOutput("mon done_layer", 32'(done_layer), 32'(exp_done));
      checkOutput("mon err_timeout", 32'(err_timeout), 32'(m_err));
      checkOutput("mon pending", 32'(pending), 32'(pv));
    end
  end

  // ---------------- directed steps, then random phase ----------------
  initial begin
    bit saw;
    int dcnt;

    $display("[TB] start");
    doReset();

    // Single request on layer 1, frame 12.
    blank = 1'b1;
    @(negedge clk_50);
    applyStimulus(3'b010, {8'd0, 8'd12, 8'd0});
    checkOutput("t1 pending captured", 32'(pending), 32'(3'b010));
    checkOutput("t1 no start yet", 32'(ld_start), 32'd0);
    @(negedge clk_50);
    checkLaunch("t1", 1, 24'h003000);
    checkOutput("t1 pending cleared", 32'(pending), 32'd0);
    checkOutput("t1 active", 32'(active), 32'd1);
    endLoadAfter(1, 4);
    @(negedge clk_50);
    checkOutput("t1 done one cycle", 32'(done_layer), 32'd0);

    // All three at once from reset: order 0,1,2.
    doReset();
    @(negedge clk_50);
    applyStimulus(3'b111, {8'd80, 8'd14, 8'd1});
    waitStart("t2 start0");
    checkLaunch("t2 l0", 0, 24'h000400);
    endLoadAfter(0, 5);
    waitStart("t2 start1");
    checkLaunch("t2 l1", 1, 24'h003800);
    endLoadAfter(1, 5);
    waitStart("t2 start2");
    checkLaunch("t2 l2", 2, 24'h014000);
    endLoadAfter(2, 5);
    // Pointer now on 2: a full set starts again at 0.
    applyStimulus(3'b111, {8'd2, 8'd1, 8'd3});
    for (int i = 0; i < 3; i++) begin
      waitStart("t2 rotate start");
      checkOutput("t2 rotate layer", 32'(ld_layer), 32'(i));
      endLoadAfter(i, 2);
    end

    // Blank low holds off the launch.
    blank = 1'b0;
    applyStimulus(3'b001, {8'd0, 8'd0, 8'd3});
    saw = 1'b0;
    repeat (100) begin
      @(negedge clk_50);
      if (ld_start) saw = 1'b1;
    end
    checkOutput("t3 no start blank low", 32'(saw), 32'd0);
    checkOutput("t3 still pending", 32'(pending), 32'(3'b001));
    blank = 1'b1;
    @(negedge clk_50);
    checkLaunch("t3 blank", 0, 24'h000C00);
    endLoadAfter(0, 3);
    // Busy loader holds off the launch.
    ld_busy = 1'b1;
    applyStimulus(3'b001, {8'd0, 8'd0, 8'd4});
    saw = 1'b0;
    repeat (20) begin
      @(negedge clk_50);
      if (ld_start) saw = 1'b1;
    end
    checkOutput("t3 no start busy", 32'(saw), 32'd0);
    ld_busy = 1'b0;
    @(negedge clk_50);
    checkLaunch("t3 busy", 0, 24'h001000);
    endLoadAfter(0, 3);

    // Re-request of the in-flight layer: only the latest frame is reloaded.
    applyStimulus(3'b100, {8'd9, 8'd0, 8'd0});
    waitStart("t4 start");
    checkLaunch("t4 first", 2, 24'h002400);
    req_valid = 3'b100;
    req_frame = {8'd5, 8'd0, 8'd0};
    @(negedge clk_50);
    req_frame = {8'd6, 8'd0, 8'd0};
    @(negedge clk_50);
    req_valid = '0;
    checkOutput("t4 repended", 32'(pending), 32'(3'b100));
    checkOutput("t4 addr held", 32'(ld_addr), 32'h002400);
    ld_done = 1'b1;
    @(negedge clk_50);
    ld_done = 1'b0;
    checkOutput("t4 done", 32'(done_layer), 32'(3'b100));
    waitStart("t4 reload start");
    checkLaunch("t4 reload", 2, 24'h001800);
    endLoadAfter(2, 2);

    // Timeout, then the next pending request launches.
    applyStimulus(3'b011, {8'd0, 8'd2, 8'd7});
    waitStart("t5 start");
    checkLaunch("t5 first", 0, 24'h001C00);
    saw = 1'b0;
    repeat (TO) begin
      @(negedge clk_50);
      if (err_timeout) saw = 1'b1;
    end
    checkOutput("t5 no early timeout", 32'(saw), 32'd0);
    checkOutput("t5 active before timeout", 32'(active), 32'd1);
    @(negedge clk_50);
    checkOutput("t5 err set", 32'(err_timeout), 32'd1);
    checkOutput("t5 idle after timeout", 32'(active), 32'd0);
    @(negedge clk_50);
    checkLaunch("t5 next", 1, 24'h000800);
    endLoadAfter(1, 4);
    checkOutput("t5 err sticky", 32'(err_timeout), 32'd1);
    err_clr = 1'b1;
    @(negedge clk_50);
    err_clr = 1'b0;
    checkOutput("t5 err cleared", 32'(err_timeout), 32'd0);

    // Asynchronous reset in WAIT with pending work and a set error.
    applyStimulus(3'b100, {8'd3, 8'd0, 8'd0});
    waitStart("t6 start");
    repeat (TO + 1) @(negedge clk_50);
    checkOutput("t6 err before reset", 32'(err_timeout), 32'd1);
    applyStimulus(3'b010, {8'd0, 8'd1, 8'd0});
    waitStart("t6 second start");
    @(negedge clk_50);
    applyStimulus(3'b001, {8'd0, 8'd0, 8'd9});
    checkOutput("t6 active in wait", 32'(active), 32'd1);
    checkOutput("t6 pending in wait", 32'(pending), 32'(3'b001));
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t6 async ld_start", 32'(ld_start), 32'd0);
    checkOutput("t6 async active", 32'(active), 32'd0);
    checkOutput("t6 async pending", 32'(pending), 32'd0);
    checkOutput("t6 async err", 32'(err_timeout), 32'd0);
    checkOutput("t6 async done", 32'(done_layer), 32'd0);
    @(negedge clk_50);
    rst = 1'b0;
    saw = 1'b0;
    repeat (4) begin
      @(negedge clk_50);
      if (done_layer != 3'b000 || active) saw = 1'b1;
    end
    checkOutput("t6 quiet after reset", 32'(saw), 32'd0);

    // Randomized traffic against the model, with a loader responder that
    // answers 2..14 edges after launch or occasionally never.
    dcnt = 0;
    repeat (3000) begin
      @(negedge clk_50);
      ld_done = 1'b0;
      if (ld_start) begin
        if ($urandom_range(0, 7) == 0) dcnt = 0;
        else dcnt = int'($urandom_range(2, 14)) - 1;
      end else if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) ld_done = 1'b1;
      end
      blank   = ($urandom_range(0, 3) != 0);
      ld_busy = ($urandom_range(0, 4) == 0);
      err_clr = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < 3; i++) begin
        req_valid[i] = ($urandom_range(0, 5) == 0);
      end
      req_frame = 24'($urandom);
    end
    @(negedge clk_50);
    req_valid = '0;
    ld_done = 1'b0;
    err_clr = 1'b0;
    repeat (3) @(negedge clk_50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
